// File: rtl/cache_cfg_regs.sv
// cache_cfg_regs
//   AHB-Lite register slave for the cache controller. It holds the cache
//   configuration (enable, prefetch disable, data-side enable, cacheable
//   limit), two saturating hit/miss statistics counters, and a fixed ID word.
//
// Ports
//   i_hclk, i_hnreset           clock, asynchronous active-low reset
//   i_hsel .. i_hwdata          AHB-Lite slave inputs (only haddr[4:0] decoded)
//   o_hready, o_hresp, o_hrdata AHB-Lite slave outputs (zero-wait OKAY,
//                               two-cycle ERROR)
//   i_stat_hit, i_stat_miss     one-cycle statistics pulses
//   o_nbypass, o_prefetch_dis,
//   o_d_cache_en, o_climit      configuration outputs, straight from flops
//
// Register map (word offset haddr[4:2])
//   0 CTRL  1 CLIMIT  2 HIT_CNT  3 MISS_CNT  4 STATUS  5 ID  6,7 reserved
module cache_cfg_regs (
  input  logic        i_hclk,
  input  logic        i_hnreset,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [1:0]  i_htrans,
  input  logic        i_hready,
  input  logic [31:0] i_hwdata,
  output logic        o_hready,
  output logic        o_hresp,
  output logic [31:0] o_hrdata,
  input  logic        i_stat_hit,
  input  logic        i_stat_miss,
  output logic        o_nbypass,
  output logic        o_prefetch_dis,
  output logic        o_d_cache_en,
  output logic [31:0] o_climit
);

  localparam logic [31:0] ID_VALUE = 32'h4341_4331;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_CLIMIT = 3'd1;
  localparam logic [2:0] IDX_HIT    = 3'd2;
  localparam logic [2:0] IDX_MISS   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_ID     = 3'd5;

  // Response FSM: OKAY is the normal zero-wait state; an illegal transfer
  // walks through the two ERROR cycles.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_t;

  resp_state_t state_reg, state_next;

  logic        addr_valid;
  logic        bad_xfer;
  logic        acc_ok;
  logic        acc_err;
  logic [2:0]  addr_idx;

  logic        wr_pend_reg, wr_pend_next;
  logic [2:0]  wr_idx_reg, wr_idx_next;
  logic        hit_clr, miss_clr;

  logic [2:0]  ctrl_reg, ctrl_next;
  logic [31:0] climit_reg, climit_next;
  logic [31:0] hit_cnt_reg, hit_cnt_next;
  logic [31:0] miss_cnt_reg, miss_cnt_next;
  logic        hit_sat_reg, hit_sat_next;
  logic        miss_sat_reg, miss_sat_next;

  logic [31:0] rd_val;
  logic [31:0] fwd_val;
  logic [31:0] rdata_reg, rdata_next;

  // Upper address bits and htrans[0] carry no meaning for this slave.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_haddr[31:5], i_htrans[0]};

  // ---------------------------------------------------------------------
  // Address phase qualification. ERR1 holds o_hready low, so nothing can be
  // accepted there even if the bus mis-drives i_hready.
  // ---------------------------------------------------------------------
  assign addr_valid = i_hsel & i_hready & i_htrans[1] & (state_reg != ST_ERR1);
  assign bad_xfer   = (i_hsize != 3'b010) | (i_haddr[1:0] != 2'b00);
  assign acc_ok     = addr_valid & ~bad_xfer;
  assign acc_err    = addr_valid & bad_xfer;
  assign addr_idx   = i_haddr[4:2];

  // ---------------------------------------------------------------------
  // Response FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      state_reg <= ST_OKAY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = ST_OKAY;
    case (state_reg)
      ST_ERR1: state_next = ST_ERR2;
      // ERR2 already shows o_hready=1, so a new address phase is taken here
      // exactly as in OKAY.
      default: state_next = acc_err ? ST_ERR1 : ST_OKAY;
    endcase
  end

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = 1'b0;
    case (state_reg)
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = 1'b1;
      end
      ST_ERR2: begin
        o_hready = 1'b1;
        o_hresp  = 1'b1;
      end
      default: begin
        o_hready = 1'b1;
        o_hresp  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Write pipeline: the address phase only records the target; the data
  // arrives one cycle later and is committed on the edge ending that cycle.
  // A valid data phase is always exactly one cycle long.
  // ---------------------------------------------------------------------
  assign wr_pend_next = acc_ok & i_hwrite;
  assign wr_idx_next  = addr_idx;
  assign hit_clr      = wr_pend_reg & (wr_idx_reg == IDX_HIT);
  assign miss_clr     = wr_pend_reg & (wr_idx_reg == IDX_MISS);

  always_comb begin
    ctrl_next   = ctrl_reg;
    climit_next = climit_reg;
    if (wr_pend_reg) begin
      case (wr_idx_reg)
        IDX_CTRL:   ctrl_next   = i_hwdata[2:0];
        IDX_CLIMIT: climit_next = i_hwdata;
        default: ;
      endcase
    end
  end

  // Counter step: clear beats a coincident pulse; the sticky flag is raised
  // as soon as the counter reaches all-ones and the value then holds.
  function automatic logic [32:0] cnt_step(input logic [31:0] cnt,
                                           input logic        sat,
                                           input logic        pulse,
                                           input logic        clr);
    logic [31:0] inc;
    inc = cnt + 32'd1;
    if (clr) begin
      cnt_step = 33'd0;
    end else if (pulse && (cnt != CNT_MAX)) begin
      cnt_step = {sat | (inc == CNT_MAX), inc};
    end else if (pulse) begin
      cnt_step = {1'b1, cnt};
    end else begin
      cnt_step = {sat, cnt};
    end
  endfunction

  always_comb begin
    {hit_sat_next, hit_cnt_next}   = cnt_step(hit_cnt_reg, hit_sat_reg, i_stat_hit, hit_clr);
    {miss_sat_next, miss_cnt_next} = cnt_step(miss_cnt_reg, miss_sat_reg, i_stat_miss, miss_clr);
  end

  // ---------------------------------------------------------------------
  // Read path: value is sampled on the address-phase edge. If the previous
  // write to the same register is still in its data phase, its data has not
  // landed yet, so the post-write value is built from i_hwdata instead.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_val = 32'd0;
    case (addr_idx)
      IDX_CTRL:   rd_val = {29'd0, ctrl_reg};
      IDX_CLIMIT: rd_val = climit_reg;
      IDX_HIT:    rd_val = hit_cnt_reg;
      IDX_MISS:   rd_val = miss_cnt_reg;
      IDX_STATUS: rd_val = {30'd0, miss_sat_reg, hit_sat_reg};
      IDX_ID:     rd_val = ID_VALUE;
      default:    rd_val = 32'd0;
    endcase
  end

  always_comb begin
    fwd_val = rd_val;
    if (wr_pend_reg && (wr_idx_reg == addr_idx)) begin
      case (addr_idx)
        IDX_CTRL:          fwd_val = {29'd0, i_hwdata[2:0]};
        IDX_CLIMIT:        fwd_val = i_hwdata;
        IDX_HIT, IDX_MISS: fwd_val = 32'd0;
        default:           fwd_val = rd_val;
      endcase
    end
  end

  // Zero whenever the coming cycle is not a valid read data phase.
  assign rdata_next = (acc_ok & ~i_hwrite) ? fwd_val : 32'd0;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      wr_pend_reg  <= 1'b0;
      wr_idx_reg   <= 3'd0;
      ctrl_reg     <= 3'd0;
      climit_reg   <= 32'd0;
      hit_cnt_reg  <= 32'd0;
      miss_cnt_reg <= 32'd0;
      hit_sat_reg  <= 1'b0;
      miss_sat_reg <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      wr_pend_reg  <= wr_pend_next;
      wr_idx_reg   <= wr_idx_next;
      ctrl_reg     <= ctrl_next;
      climit_reg   <= climit_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      hit_sat_reg  <= hit_sat_next;
      miss_sat_reg <= miss_sat_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign o_hrdata       = rdata_reg;
  assign o_nbypass      = ctrl_reg[0];
  assign o_prefetch_dis = ctrl_reg[1];
  assign o_d_cache_en   = ctrl_reg[2];
  assign o_climit       = climit_reg;

endmodule

// File: tb/tb_cache_cfg_regs.sv
module tb_cache_cfg_regs;

  localparam logic [31:0] ID_VALUE = 32'h4341_4331;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;
  logic        stat_hit;
  logic        stat_miss;
  logic        nbypass;
  logic        prefetch_dis;
  logic        d_cache_en;
  logic [31:0] climit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // The interconnect returns the selected slave's ready as the bus ready.
  assign hready_in = hready_out;

  cache_cfg_regs dut (
    .i_hclk         (clk),
    .i_hnreset      (rst_n),
    .i_hsel         (hsel),
    .i_haddr        (haddr),
    .i_hwrite       (hwrite),
    .i_hsize        (hsize),
    .i_htrans       (htrans),
    .i_hready       (hready_in),
    .i_hwdata       (hwdata),
    .o_hready       (hready_out),
    .o_hresp        (hresp),
    .o_hrdata       (hrdata),
    .i_stat_hit     (stat_hit),
    .i_stat_miss    (stat_miss),
    .o_nbypass      (nbypass),
    .o_prefetch_dis (prefetch_dis),
    .o_d_cache_en   (d_cache_en),
    .o_climit       (climit)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", what, act, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'd0;
    hwrite = 1'b0;
    hsize  = 3'd2;
  endtask

  // One isolated transfer; checks the data-phase response and read data.
  task automatic do_xfer(input string name, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wdata,
                         input logic err, input logic [31:0] exp);
    @(negedge clk);
    addr_phase(wr, a, sz);
    @(negedge clk);
    idle_bus();
    if (wr) hwdata = wdata;
    check({name, " rdata"}, hrdata, (wr || err) ? 32'd0 : exp);
    if (err) begin
      check({name, " e1 hready"}, 32'(hready_out), 32'd0);
      check({name, " e1 hresp"}, 32'(hresp), 32'd1);
      @(negedge clk);
      check({name, " e2 hready"}, 32'(hready_out), 32'd1);
      check({name, " e2 hresp"}, 32'(hresp), 32'd1);
      @(negedge clk);
      check({name, " after hresp"}, 32'(hresp), 32'd0);
    end else begin
      check({name, " hready"}, 32'(hready_out), 32'd1);
      check({name, " hresp"}, 32'(hresp), 32'd0);
    end
    $display("xfer %s wr=%0d addr=%h size=%0d wdata=%h rdata=%h", name, wr, a, sz, wdata, hrdata);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    do_xfer(name, 1'b0, a, 3'd2, 32'd0, 1'b0, exp);
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
    do_xfer(name, 1'b1, a, 3'd2, d, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              wr    addr           size  wdata          err   exp
    vecs[0]  = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0014, 3'd2, 32'h0,         1'b0, ID_VALUE};
    vecs[2]  = '{1'b1, 32'h0000_0000, 3'd2, 32'hFFFF_FFFA, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         1'b0, 32'h2};
    vecs[4]  = '{1'b1, 32'h0000_0004, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0004, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h0000_0014, 3'd2, 32'h0,         1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFF4, 3'd2, 32'h0,         1'b0, ID_VALUE};
    vecs[8]  = '{1'b1, 32'h0000_001C, 3'd2, 32'h5,         1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_001C, 3'd2, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0010, 3'd2, 32'hFF,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0006, 3'd2, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0004, 3'd1, 32'h1234_5678, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0024, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, 32'h0000_0018, 3'd2, 32'h0,         1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0000_0008, 3'd2, 32'h0,         1'b0, 32'h0};

    rst_n     = 1'b0;
    hwdata    = 32'd0;
    stat_hit  = 1'b0;
    stat_miss = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst hready", 32'(hready_out), 32'd1);
    check("rst hresp", 32'(hresp), 32'd0);
    check("rst hrdata", hrdata, 32'd0);
    check("rst ctrl", {29'd0, d_cache_en, prefetch_dis, nbypass}, 32'd0);
    check("rst climit", climit, 32'd0);
    rst_n = 1'b1;

    // Byte write to CLIMIT errors; a read issued in ERR cycle 2 is accepted.
    @(negedge clk);
    addr_phase(1'b1, 32'h4, 3'd0);
    @(negedge clk);
    idle_bus();
    hwdata = 32'hAAAA_5555;
    check("berr e1 hready", 32'(hready_out), 32'd0);
    check("berr e1 hresp", 32'(hresp), 32'd1);
    @(negedge clk);
    check("berr e2 hready", 32'(hready_out), 32'd1);
    check("berr e2 hresp", 32'(hresp), 32'd1);
    addr_phase(1'b0, 32'h14, 3'd2);
    @(negedge clk);
    idle_bus();
    check("err2 rd hready", 32'(hready_out), 32'd1);
    check("err2 rd hresp", 32'(hresp), 32'd0);
    check("err2 rd rdata", hrdata, ID_VALUE);
    check("berr climit", climit, 32'd0);
    $display("xfer byte-write error then ID read rdata=%h climit=%h", hrdata, climit);

    // Table-driven register access
    for (int i = 0; i < 17; i++) begin
      do_xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
              vecs[i].wdata, vecs[i].err, vecs[i].exp);
    end
    check("tbl nbypass", 32'(nbypass), 32'd0);
    check("tbl prefetch_dis", 32'(prefetch_dis), 32'd1);
    check("tbl d_cache_en", 32'(d_cache_en), 32'd0);
    check("tbl climit", climit, 32'hDEAD_BEEF);

    // Back-to-back write CTRL then read CTRL: forwarded read data
    @(negedge clk);
    addr_phase(1'b1, 32'h0, 3'd2);
    @(negedge clk);
    hwdata = 32'h5;
    addr_phase(1'b0, 32'h0, 3'd2);
    check("fwd dphase nbypass", 32'(nbypass), 32'd0);
    @(negedge clk);
    idle_bus();
    check("fwd rdata", hrdata, 32'h5);
    check("fwd nbypass", 32'(nbypass), 32'd1);
    check("fwd d_cache_en", 32'(d_cache_en), 32'd1);
    check("fwd prefetch_dis", 32'(prefetch_dis), 32'd0);
    $display("xfer b2b ctrl write/read rdata=%h", hrdata);

    // 10 hits, 3 misses, 2 of them coincident
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      stat_hit  = (i < 10);
      stat_miss = (i < 2) || (i == 10);
    end
    @(negedge clk);
    stat_hit  = 1'b0;
    stat_miss = 1'b0;
    rd("hit10", 32'h8, 32'd10);
    rd("miss3", 32'hC, 32'd3);
    rd("stat0", 32'h10, 32'd0);

    // Saturation of HIT_CNT
    @(negedge clk);
    force dut.hit_cnt_reg = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.hit_cnt_reg;
    rd("hit preset", 32'h8, 32'hFFFF_FFFE);
    rd("stat preset", 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stat_hit = 1'b1;
      @(negedge clk);
      stat_hit = 1'b0;
    end
    rd("hit sat", 32'h8, 32'hFFFF_FFFF);
    rd("stat sat", 32'h10, 32'h1);
    wr("hit clr", 32'h8, 32'h1234);
    rd("hit cleared", 32'h8, 32'd0);
    rd("stat cleared", 32'h10, 32'd0);

    // Clear MISS_CNT on the same edge as a miss pulse (and a hit pulse)
    @(negedge clk);
    addr_phase(1'b1, 32'hC, 3'd2);
    @(negedge clk);
    idle_bus();
    hwdata    = 32'd0;
    stat_miss = 1'b1;
    stat_hit  = 1'b1;
    @(negedge clk);
    stat_miss = 1'b0;
    stat_hit  = 1'b0;
    $display("xfer miss clear with coincident pulses");
    rd("miss clr wins", 32'hC, 32'd0);
    rd("hit indep", 32'h8, 32'd1);

    // Reset during a CLIMIT write data phase
    @(negedge clk);
    addr_phase(1'b1, 32'h4, 3'd2);
    @(negedge clk);
    idle_bus();
    hwdata = 32'h1234;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid climit", climit, 32'd0);
    check("rstmid hready", 32'(hready_out), 32'd1);
    check("rstmid hresp", 32'(hresp), 32'd0);
    check("rstmid nbypass", 32'(nbypass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst climit", climit, 32'd0);
    $display("xfer reset mid-write climit=%h", climit);
    rd("postrst id", 32'h14, ID_VALUE);
    rd("postrst climit rd", 32'h4, 32'd0);
    rd("postrst hit", 32'h8, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
